contador_cfg_bcd: RTL and testbench

Parametrised up/down configuration counter for one RTC date/time field (month, day, hour, minute, ...). Wraps within [MIN_VAL, MAX_VAL] and reports the value as 2-digit BCD for the display and RTC write path. Supports a load from RTC read-back data and emits change, carry and borrow strobes. One instance is used per field, each selected by the shared field-select bus.

---
 rtl/contador_cfg_bcd.sv | 185 ++++++++++++++++++
 tb/tb_contador_cfg_bcd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_cfg_bcd.sv
// Up/down wrap counter for one RTC field with a 2-digit BCD view, RTC load and carry/borrow strobes.
// Latency: an input seen at a rising edge updates valor_bin, valor_bcd and the strobes at that edge.
// No backpressure: buttons and load are level/strobe inputs; strobes last one cycle per event.
// Optional auto-repeat while a button is held: define CONTADOR_CFG_AUTOREPEAT_EN.
module contador_cfg_bcd #(
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 12,
    parameter int SEL_W   = 4,
    parameter int SEL_ID  = 5,
    parameter int REP_DLY = 50000000,
    parameter int REP_PER = 13000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             arriba,
    input  logic             abajo,
    input  logic             load,
    input  logic [7:0]       load_bcd,
    output logic [7:0]       valor_bcd,
    output logic [6:0]       valor_bin,
    output logic             cambio,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             activo
);

    localparam logic [6:0]       MIN_V    = 7'(MIN_VAL);
    localparam logic [6:0]       MAX_V    = 7'(MAX_VAL);
    localparam logic [SEL_W-1:0] SEL_CODE = SEL_W'(SEL_ID);

    // Reject illegal field ranges and zero repeat timings at elaboration.
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
        $error("contador_cfg_bcd: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end
    if (REP_DLY < 1 || REP_PER < 1) begin : g_bad_rep
        $error("contador_cfg_bcd: REP_DLY and REP_PER must be at least 1");
    end

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 7'd10);
        u = 4'(v - 7'(t) * 7'd10);
        return {t, u};
    endfunction

    logic       arriba_q;
    logic       abajo_q;
    logic       edge_up;
    logic       edge_dn;
    logic       rep_up;
    logic       rep_dn;
    logic       step_up;
    logic       step_dn;
    logic [3:0] ld_tens;
    logic [3:0] ld_units;
    logic [6:0] ld_bin;
    logic       ld_ok;
    logic [6:0] nxt_bin;
    logic       nxt_cambio;
    logic       nxt_carry;
    logic       nxt_borrow;
    logic       nxt_err;

    assign activo   = (sel == SEL_CODE);
    // A press only counts while the other button is idle, so a chord never steps.
    assign edge_up  = arriba & ~arriba_q & ~abajo & activo;
    assign edge_dn  = abajo & ~abajo_q & ~arriba & activo;
    assign step_up  = edge_up | rep_up;
    assign step_dn  = edge_dn | rep_dn;

    assign ld_tens  = load_bcd[7:4];
    assign ld_units = load_bcd[3:0];
    assign ld_bin   = 7'(ld_tens) * 7'd10 + 7'(ld_units);
    assign ld_ok    = (ld_tens <= 4'd9) && (ld_units <= 4'd9) &&
                      (ld_bin >= MIN_V) && (ld_bin <= MAX_V);

`ifdef CONTADOR_CFG_AUTOREPEAT_EN
    logic        rep_arm;
    logic        rep_dir_up;
    logic        rep_first;
    logic [31:0] rep_cnt;
    logic [31:0] rep_thr;
    logic        hold_one;
    logic        hold_dir;
    logic        rep_fire;

    assign hold_one = activo & (arriba ^ abajo);
    assign hold_dir = rep_dir_up ? arriba : abajo;
    assign rep_thr  = rep_first ? 32'(REP_DLY) : 32'(REP_PER);
    assign rep_fire = rep_arm & hold_one & hold_dir & ~load & (rep_cnt + 32'd1 == rep_thr);
    assign rep_up   = rep_fire & rep_dir_up;
    assign rep_dn   = rep_fire & ~rep_dir_up;

    // Repeat timer: armed by an accepted press edge, disarmed by anything that ends a clean hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_arm    <= 1'b0;
            rep_dir_up <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (load || !hold_one) begin
            rep_arm <= 1'b0;
            rep_cnt <= '0;
        end else if (edge_up || edge_dn) begin
            rep_arm    <= 1'b1;
            rep_dir_up <= edge_up;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (rep_arm && hold_dir) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 32'd1;
            end
        end else begin
            rep_arm <= 1'b0;
            rep_cnt <= '0;
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    // Next value and strobes: load beats step, step beats hold.
    always_comb begin
        nxt_bin    = valor_bin;
        nxt_cambio = 1'b0;
        nxt_carry  = 1'b0;
        nxt_borrow = 1'b0;
        nxt_err    = 1'b0;
        if (load) begin
            if (ld_ok) begin
                nxt_bin    = ld_bin;
                nxt_cambio = (ld_bin != valor_bin);
            end else begin
                nxt_err = 1'b1;
            end
        end else if (step_up) begin
            nxt_cambio = 1'b1;
            if (valor_bin == MAX_V) begin
                nxt_bin   = MIN_V;
                nxt_carry = 1'b1;
            end else begin
                nxt_bin = valor_bin + 7'd1;
            end
        end else if (step_dn) begin
            nxt_cambio = 1'b1;
            if (valor_bin == MIN_V) begin
                nxt_bin    = MAX_V;
                nxt_borrow = 1'b1;
            end else begin
                nxt_bin = valor_bin - 7'd1;
            end
        end
    end

    // Value, its BCD image and the one-cycle strobes are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arriba_q  <= 1'b0;
            abajo_q   <= 1'b0;
            valor_bin <= MIN_V;
            valor_bcd <= to_bcd(MIN_V);
            cambio    <= 1'b0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            arriba_q  <= arriba;
            abajo_q   <= abajo;
            valor_bin <= nxt_bin;
            valor_bcd <= to_bcd(nxt_bin);
            cambio    <= nxt_cambio;
            carry     <= nxt_carry;
            borrow    <= nxt_borrow;
            load_err  <= nxt_err;
        end
    end

endmodule

// File: tb/tb_contador_cfg_bcd.sv
// Directed bench for contador_cfg_bcd with MIN=1, MAX=12, SEL_ID=5, REP_DLY=8, REP_PER=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected auto-repeat results follow CONTADOR_CFG_AUTOREPEAT_EN as defined for the build.
module tb_contador_cfg_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sel;
    logic       arriba;
    logic       abajo;
    logic       load;
    logic [7:0] load_bcd;
    logic [7:0] valor_bcd;
    logic [6:0] valor_bin;
    logic       cambio;
    logic       carry;
    logic       borrow;
    logic       load_err;
    logic       activo;

    int total = 0;
    int bad   = 0;
    int n_cambio;
    int n_carry;

`ifdef CONTADOR_CFG_AUTOREPEAT_EN
    localparam int HOLD30_VAL   = 8;
    localparam int HOLD30_STEPS = 7;
    localparam int MID_VAL      = 3;
`else
    localparam int HOLD30_VAL   = 2;
    localparam int HOLD30_STEPS = 1;
    localparam int MID_VAL      = 2;
`endif

    contador_cfg_bcd #(
        .MIN_VAL(1), .MAX_VAL(12), .SEL_W(4), .SEL_ID(5), .REP_DLY(8), .REP_PER(4)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .arriba(arriba), .abajo(abajo),
        .load(load), .load_bcd(load_bcd), .valor_bcd(valor_bcd), .valor_bin(valor_bin),
        .cambio(cambio), .carry(carry), .borrow(borrow), .load_err(load_err), .activo(activo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    // One-cycle button pulse; leaves the bench just after the edge that saw it.
    task automatic pulse(input logic up);
        if (up) arriba = 1'b1; else abajo = 1'b1;
        tick();
        arriba = 1'b0;
        abajo  = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_bcd = v;
        tick();
        load = 1'b0;
    endtask

    task automatic hold_count(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cambio) n_cambio++;
        end
    endtask

    initial begin
        reset = 1'b1; sel = 4'd5; arriba = 0; abajo = 0; load = 0; load_bcd = 8'h00;
        #12;
        check("rst_bin", valor_bin, 1);
        check("rst_bcd", valor_bcd, 8'h01);
        check("rst_strb", {cambio, carry, borrow, load_err}, 0);
        reset = 1'b0;
        tick();
        check("post_rst_bin", valor_bin, 1);
        check("activo_on", activo, 1);

        // Twelve up pulses: BCD at 10, wrap with carry on the last.
        n_cambio = 0; n_carry = 0;
        for (int i = 1; i <= 12; i++) begin
            pulse(1'b1);
            if (cambio) n_cambio++;
            if (carry) n_carry++;
            check("up_carry", carry, (i == 12) ? 1 : 0);
            if (i == 9) check("up9_bcd", valor_bcd, 8'h10);
            if (i == 11) check("up11_bcd", valor_bcd, 8'h12);
            tick();
            check("strobe_1cyc", {cambio, carry}, 0);
        end
        check("up12_bin", valor_bin, 1);
        check("up_cambio_cnt", n_cambio, 12);
        check("up_carry_cnt", n_carry, 1);

        // Down wrap with borrow, then editing another field.
        pulse(1'b0);
        check("dn_bin", valor_bin, 12);
        check("dn_bcd", valor_bcd, 8'h12);
        check("dn_borrow", borrow, 1);
        check("dn_carry", carry, 0);
        tick();
        check("borrow_clr", borrow, 0);
        sel = 4'd3;
        #1;
        check("activo_off", activo, 0);
        pulse(1'b1);
        check("nosel_cambio", cambio, 0);
        check("nosel_bin", valor_bin, 12);
        tick();
        sel = 4'd5;

        // Loads, including one that collides with a press edge.
        do_load(8'h09);
        check("ld9_bin", valor_bin, 9);
        check("ld9_cambio", cambio, 1);
        check("ld9_err", load_err, 0);
        do_load(8'h13);
        check("ld13_err", load_err, 1);
        check("ld13_bin", valor_bin, 9);
        do_load(8'h0A);
        check("ld0a_err", load_err, 1);
        check("ld0a_bcd", valor_bcd, 8'h09);
        do_load(8'h09);
        check("ld9b_cambio", cambio, 0);
        check("ld9b_err", load_err, 0);
        arriba = 1'b1;
        do_load(8'h04);
        check("ldstep_bin", valor_bin, 4);
        check("ldstep_bcd", valor_bcd, 8'h04);
        arriba = 1'b0;
        tick();
        check("ldstep_late", valor_bin, 4);
        do_load(8'h00);
        check("ld00_err", load_err, 1);
        tick();

        // Chords never step.
        arriba = 1'b1; abajo = 1'b1;
        tick();
        check("both_cambio", cambio, 0);
        check("both_bin", valor_bin, 4);
        arriba = 1'b0; abajo = 1'b0;
        tick();
        arriba = 1'b1;
        tick();
        check("hold_up_bin", valor_bin, 5);
        tick();
        abajo = 1'b1;
        tick();
        check("second_cambio", cambio, 0);
        check("second_bin", valor_bin, 5);
        arriba = 1'b0; abajo = 1'b0;
        tick();
        tick();

        // Long hold from 1.
        do_reset();
        n_cambio = 0;
        arriba = 1'b1;
        hold_count(30);
        arriba = 1'b0;
        check("hold30_bin", valor_bin, HOLD30_VAL);
        check("hold30_bcd", valor_bcd, {4'h0, 4'(HOLD30_VAL)});
        check("hold30_steps", n_cambio, HOLD30_STEPS);
        tick();

        // sel drops mid-hold, then returns with the button still down.
        do_reset();
        n_cambio = 0;
        arriba = 1'b1;
        hold_count(10);
        check("mid_bin", valor_bin, MID_VAL);
        n_cambio = 0;
        sel = 4'd3;
        hold_count(10);
        sel = 4'd5;
        hold_count(10);
        check("mid_nostep", n_cambio, 0);
        check("mid_bin_end", valor_bin, MID_VAL);
        arriba = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
